// File: rtl/mux_scan_controller.sv
// Scan controller wrapped around a 4:1 structural mux.
// Steps the mux select lines through every enabled channel in ascending
// order, holds each address for DWELL cycles, captures mux_out into the
// matching sample bit, then pulses valid for one cycle.
module mux_scan_controller #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] chan_mask,
  input  logic       mux_out,
  output logic       addr0,
  output logic       addr1,
  output logic [3:0] sample,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter reload value; DWELL up to 2^CNT_W still fits after the minus one.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t           state, state_nx;
  logic [1:0]       ch, ch_nx;
  logic [3:0]       mask_q, mask_nx;
  logic [3:0]       sample_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             busy_nx;
  logic             valid_nx;

  logic [1:0]       first_ch;
  logic             first_hit;
  logic [1:0]       next_ch;
  logic             next_hit;

  // The current channel register drives the mux select lines directly.
  assign addr0 = ch[0];
  assign addr1 = ch[1];

  // Lowest enabled channel of the incoming mask (scan entry point).
  always_comb begin
    first_ch  = '0;
    first_hit = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!first_hit && chan_mask[i]) begin
        first_ch  = 2'(i);
        first_hit = 1'b1;
      end
    end
  end

  // Next enabled channel above the current one in the latched mask; no wrap.
  always_comb begin
    next_ch  = '0;
    next_hit = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!next_hit && mask_q[i] && (i > 32'(ch))) begin
        next_ch  = 2'(i);
        next_hit = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the scan sequencer.
  always_comb begin
    state_nx  = state;
    ch_nx     = ch;
    mask_nx   = mask_q;
    sample_nx = sample;
    cnt_nx    = cnt;
    busy_nx   = busy;
    valid_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sample_nx = '0;
          if (chan_mask != '0) begin
            mask_nx  = chan_mask;
            ch_nx    = first_ch;
            cnt_nx   = RELOAD;
            busy_nx  = 1'b1;
            state_nx = SCAN;
          end else begin
            // Empty mask completes immediately without ever raising busy.
            valid_nx = 1'b1;
            state_nx = DONE;
          end
        end
      end

      SCAN: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          sample_nx[ch] = mux_out;
          if (next_hit) begin
            ch_nx  = next_ch;
            cnt_nx = RELOAD;
          end else begin
            busy_nx  = 1'b0;
            valid_nx = 1'b1;
            state_nx = DONE;
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ch     <= '0;
      mask_q <= '0;
      sample <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nx;
      ch     <= ch_nx;
      mask_q <= mask_nx;
      sample <= sample_nx;
      cnt    <= cnt_nx;
      busy   <= busy_nx;
      valid  <= valid_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench for mux_scan_controller with a behavioural 4:1 mux.
// The driver issues scans and queues the expected outcome of each; a
// negedge monitor compares busy/addr/valid/sample against the queue head.
module tb_mux_scan_controller;

  localparam int unsigned DWELL = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] chan_mask;
  logic       mux_out;
  logic       addr0;
  logic       addr1;
  logic [3:0] sample;
  logic       busy;
  logic       valid;

  logic [3:0] ins = 4'b0000;

  mux_scan_controller #(.DWELL(DWELL), .CNT_W(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .chan_mask(chan_mask),
    .mux_out  (mux_out),
    .addr0    (addr0),
    .addr1    (addr1),
    .sample   (sample),
    .busy     (busy),
    .valid    (valid)
  );

  // Behavioural mux closing the loop around the controller.
  assign mux_out = ins[{addr1, addr0}];

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned k;
    logic [3:0]  mask;
    logic [3:0]  exp;
  } scan_t;

  scan_t       sbq[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  bit          mon_en = 1'b0;
  int unsigned free_edge = 0;
  logic [1:0]  exp_addr = 2'd0;
  logic [3:0]  exp_sample = 4'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Index of the j-th set bit of m, counting from bit 0.
  function automatic logic [1:0] nth_en(input logic [3:0] m, input int unsigned j);
    int unsigned seen;
    seen = 0;
    nth_en = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (seen == j) nth_en = 2'(i);
        seen++;
      end
    end
  endfunction

  // Monitor: the edge count after edge e is cyc==e at the following negedge.
  scan_t       cur;
  int unsigned n_en;
  int unsigned span;
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (sbq.size() > 0 && cyc >= sbq[0].k) begin
        cur  = sbq[0];
        n_en = $countones(cur.mask);
        span = n_en * DWELL;
        if (cyc < cur.k + span) begin
          chk("scan_busy", 8'(busy), 8'd1);
          chk("scan_valid", 8'(valid), 8'd0);
          chk("scan_addr", 8'({addr1, addr0}), 8'(nth_en(cur.mask, (cyc - cur.k) / DWELL)));
        end else begin
          chk("done_valid", 8'(valid), 8'd1);
          chk("done_busy", 8'(busy), 8'd0);
          chk("done_sample", 8'(sample), 8'(cur.exp));
          if (n_en > 0) exp_addr = nth_en(cur.mask, n_en - 1);
          chk("done_addr", 8'({addr1, addr0}), 8'(exp_addr));
          exp_sample = cur.exp;
          void'(sbq.pop_front());
        end
      end else begin
        chk("idle_valid", 8'(valid), 8'd0);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_addr", 8'({addr1, addr0}), 8'(exp_addr));
        chk("idle_sample", 8'(sample), 8'(exp_sample));
      end
    end
  end

  // Issue one scan at the first edge the controller is back in IDLE.
  task automatic issue(input logic [3:0] m, input logic [3:0] in_v, input bit hold);
    scan_t e;
    while (cyc + 1 < free_edge) @(negedge clk);
    ins       = in_v;
    chan_mask = m;
    start     = 1'b1;
    e.k    = cyc + 1;
    e.mask = m;
    e.exp  = in_v & m;
    sbq.push_back(e);
    free_edge = e.k + $countones(m) * DWELL + 2;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    chan_mask = 4'b0000;
    #1;
    chk("reset_addr", 8'({addr1, addr0}), 8'd0);
    chk("reset_sample", 8'(sample), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_valid", 8'(valid), 8'd0);
    repeat (3) @(negedge clk);
    reset_n   = 1'b1;
    mon_en    = 1'b1;
    free_edge = cyc + 2;

    // Full scan: in0..in3 = 1,0,1,1.
    issue(4'b1111, 4'b1101, 1'b0);
    // Sparse scan: in1=1, in3=0, others random.
    issue(4'b1010, 4'b0010 | (4'($urandom) & 4'b0101), 1'b0);
    // Empty mask.
    issue(4'b0000, 4'($urandom), 1'b0);

    // start and a new mask while busy must not disturb the running scan.
    issue(4'b1111, 4'($urandom), 1'b0);
    repeat (2) @(negedge clk);
    start     = 1'b1;
    chan_mask = 4'b0001;
    repeat (5) @(negedge clk);
    start     = 1'b0;

    // Back-to-back with start held high, in2 toggled between scans.
    for (int i = 0; i < 6; i++) begin
      issue(4'b0100, {1'b0, i[0], 2'b00} | (4'($urandom) & 4'b1011), i < 5);
    end

    // Randomized scans, sometimes chained with start held.
    for (int i = 0; i < 40; i++) begin
      issue(4'($urandom), 4'($urandom), (i < 39) && ($urandom_range(0, 1) == 1));
    end

    // Reset two cycles after a full-mask start.
    issue(4'b1111, 4'($urandom), 1'b0);
    @(negedge clk);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midreset_addr", 8'({addr1, addr0}), 8'd0);
    chk("midreset_sample", 8'(sample), 8'd0);
    chk("midreset_busy", 8'(busy), 8'd0);
    chk("midreset_valid", 8'(valid), 8'd0);
    sbq.delete();
    exp_addr   = 2'd0;
    exp_sample = 4'd0;
    @(negedge clk);
    reset_n   = 1'b1;
    mon_en    = 1'b1;
    free_edge = cyc + 2;
    repeat (10) @(negedge clk);

    // One more scan to confirm normal operation after reset.
    issue(4'b0011, 4'($urandom), 1'b0);
    repeat (DWELL * 2 + 4) @(negedge clk);
    chk("queue_drained", 8'(sbq.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
